// File: rtl/ctrl_pipe_pkg.sv
// Shared decode constants and control-bundle types for the pipelined main controller.
package ctrl_pipe_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;   // BGEZ lives here
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU operations; NOP must stay zero so a bubble is the all-zero bundle
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_ADDU = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_SUBU = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_SLT  = 4'd11
    } alu_op_e;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] SHIFT_NONE  = 2'd0;
    localparam logic [1:0] SHIFT_SHAMT = 2'd1;
    localparam logic [1:0] SHIFT_LUI   = 2'd2;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BGEZ = 3'd4;

    // Full control bundle as it enters EX
    typedef struct packed {
        alu_op_e    aluop;
        logic       alusrc;
        logic [1:0] regdst;
        logic [1:0] shift;
        logic       link;
        logic       illegal;
        logic       readmem;
        logic       writemem;
        logic       regwrite;
        logic       memtoreg;
    } ctrl_t;

    // Controls still needed once the instruction leaves EX
    typedef struct packed {
        logic readmem;
        logic writemem;
        logic regwrite;
        logic memtoreg;
        logic link;
    } mem_ctrl_t;

    // Controls still needed once the instruction leaves MEM
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic link;
    } wb_ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Strip EX-only fields; illegal is intentionally dropped here
    function automatic mem_ctrl_t to_mem(input ctrl_t c);
        mem_ctrl_t m;
        m.readmem  = c.readmem;
        m.writemem = c.writemem;
        m.regwrite = c.regwrite;
        m.memtoreg = c.memtoreg;
        m.link     = c.link;
        return m;
    endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Purely combinational ID-stage decode of opcode/func into a control bundle.
module ctrl_pipe_decode
    import ctrl_pipe_pkg::*;
#(
    parameter int EN_JUMP = 1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       id_valid,
    output logic       id_jump,
    output logic       id_jreg,
    output logic [2:0] id_branch,
    output ctrl_t      id_ctrl
);

    // Decode table; everything defaults to a bubble so no path can latch
    always_comb begin
        id_ctrl   = CTRL_BUBBLE;
        id_jump   = 1'b0;
        id_jreg   = 1'b0;
        id_branch = BR_NONE;
        if (id_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    id_ctrl.regdst   = REGDST_RD;
                    id_ctrl.regwrite = 1'b1;
                    case (func)
                        FN_ADD:  id_ctrl.aluop = ALU_ADD;
                        FN_ADDU: id_ctrl.aluop = ALU_ADDU;
                        FN_SUB:  id_ctrl.aluop = ALU_SUB;
                        FN_SUBU: id_ctrl.aluop = ALU_SUBU;
                        FN_AND:  id_ctrl.aluop = ALU_AND;
                        FN_OR:   id_ctrl.aluop = ALU_OR;
                        FN_NOR:  id_ctrl.aluop = ALU_NOR;
                        FN_SLT:  id_ctrl.aluop = ALU_SLT;
                        FN_SLL: begin
                            id_ctrl.aluop = ALU_SLL;
                            id_ctrl.shift = SHIFT_SHAMT;
                        end
                        FN_SRL: begin
                            id_ctrl.aluop = ALU_SRL;
                            id_ctrl.shift = SHIFT_SHAMT;
                        end
                        FN_SRA: begin
                            id_ctrl.aluop = ALU_SRA;
                            id_ctrl.shift = SHIFT_SHAMT;
                        end
                        FN_JR: begin
                            // JR is handled by the jump path, nothing is written back
                            id_jump          = 1'b1;
                            id_jreg          = 1'b1;
                            id_ctrl.regwrite = 1'b0;
                        end
                        default: begin
                            id_ctrl         = CTRL_BUBBLE;
                            id_ctrl.illegal = 1'b1;
                        end
                    endcase
                end
                OP_ADDI, OP_ADDIU: begin
                    id_ctrl.aluop    = ALU_ADD;
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                end
                OP_SLTI: begin
                    id_ctrl.aluop    = ALU_SLT;
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                end
                OP_ANDI: begin
                    id_ctrl.aluop    = ALU_AND;
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                end
                OP_ORI: begin
                    id_ctrl.aluop    = ALU_OR;
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                end
                OP_LUI: begin
                    id_ctrl.aluop    = ALU_SLL;
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.shift    = SHIFT_LUI;
                    id_ctrl.regwrite = 1'b1;
                end
                OP_LW: begin
                    id_ctrl.aluop    = ALU_ADD;
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.readmem  = 1'b1;
                    id_ctrl.memtoreg = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                end
                OP_SW: begin
                    id_ctrl.aluop    = ALU_ADD;
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.writemem = 1'b1;
                end
                OP_BEQ:    id_branch = BR_BEQ;
                OP_BNE:    id_branch = BR_BNE;
                OP_BGTZ:   id_branch = BR_BGTZ;
                OP_REGIMM: id_branch = BR_BGEZ;
                OP_J: begin
                    if (EN_JUMP != 0) begin
                        id_jump = 1'b1;
                    end else begin
                        id_ctrl.illegal = 1'b1;
                    end
                end
                OP_JAL: begin
                    if (EN_JUMP != 0) begin
                        id_jump          = 1'b1;
                        id_ctrl.link     = 1'b1;
                        id_ctrl.regdst   = REGDST_RA;
                        id_ctrl.regwrite = 1'b1;
                    end else begin
                        id_ctrl.illegal = 1'b1;
                    end
                end
                default: id_ctrl.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Main controller: ID decode plus registered ID/EX, EX/MEM and MEM/WB control stages.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int EN_JUMP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               id_valid,
    input  logic               stall,
    input  logic               flush,
    output logic               id_jump,
    output logic               id_jreg,
    output logic [2:0]         id_branch,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic [1:0]         ex_regdst,
    output logic [1:0]         ex_shift,
    output logic               ex_link,
    output logic               ex_illegal,
    output logic               mem_readmem,
    output logic               mem_writemem,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic               wb_link
);

    ctrl_t     id_ctrl;
    ctrl_t     ex_d;
    ctrl_t     ex_q;
    mem_ctrl_t mem_q;
    wb_ctrl_t  wb_q;

    ctrl_pipe_decode #(
        .EN_JUMP(EN_JUMP)
    ) u_decode (
        .opcode   (opcode),
        .func     (func),
        .id_valid (id_valid),
        .id_jump  (id_jump),
        .id_jreg  (id_jreg),
        .id_branch(id_branch),
        .id_ctrl  (id_ctrl)
    );

    // Hazard and branch units both turn the ID/EX load into a bubble
    always_comb begin
        ex_d = id_ctrl;
        if (stall || flush) begin
            ex_d = CTRL_BUBBLE;
        end
    end

    // ID/EX stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= CTRL_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM and MEM/WB always advance; this block never stalls them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= to_mem(ex_q);
            wb_q  <= '{regwrite: mem_q.regwrite, memtoreg: mem_q.memtoreg, link: mem_q.link};
        end
    end

    assign ex_aluop     = ALUOP_W'(ex_q.aluop);
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_regdst    = ex_q.regdst;
    assign ex_shift     = ex_q.shift;
    assign ex_link      = ex_q.link;
    assign ex_illegal   = ex_q.illegal;
    assign mem_readmem  = mem_q.readmem;
    assign mem_writemem = mem_q.writemem;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_link      = wb_q.link;

endmodule
